// File: rtl/sync_transmitter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sync_pkg: shared constants and FSM encoding for sync link   rev 1.0|
// +-------------------------------------------------------------------+
package sync_pkg;

  localparam int FRAME_BITS  = 10;
  localparam int DEF_SEC_DIV = 10_000_000;
  localparam int DEF_BIT_DIV = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_transmitter_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sync_transmitter_if: control strobes, serial line, status   rev 1.0|
// +-------------------------------------------------------------------+
interface sync_transmitter_if;

  logic       time_load;
  logic [7:0] time_in;
  logic       sync_req;
  logic       tx_line;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] time_second;
  logic       sec_tick;
  logic       overrun;

  modport master (
    output time_load, time_in, sync_req,
    input  tx_line, tx_busy, tx_done, time_second, sec_tick, overrun
  );

  modport slave (
    input  time_load, time_in, sync_req,
    output tx_line, tx_busy, tx_done, time_second, sec_tick, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sync_time_base.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sync_time_base: seconds prescaler, counter and load path    rev 1.0|
// +-------------------------------------------------------------------+
module sync_time_base
  import sync_pkg::*;
#(
  parameter int SEC_DIV = DEF_SEC_DIV
) (
  input  wire logic       clk_10M,
  input  wire logic       rst,
  input  wire logic       time_load_i,
  input  wire logic [7:0] time_in_i,
  output logic [7:0]      time_second_o,
  output logic            sec_tick_o,
  output logic [7:0]      sec_next_o
);

  localparam int CW = $clog2(SEC_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sec_q, sec_d;
  logic          tick;

  assign tick = (cnt_q == CW'(SEC_DIV - 1));

  // A load wins over the increment but never suppresses the tick itself.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    sec_d = tick ? sec_q + 8'd1 : sec_q;
    if (time_load_i) begin
      cnt_d = '0;
      sec_d = time_in_i;
    end
  end

  always_ff @(posedge clk_10M) begin
    if (rst) begin
      cnt_q <= '0;
      sec_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      sec_q <= sec_d;
    end
  end

  assign time_second_o = sec_q;
  assign sec_tick_o    = tick;
  assign sec_next_o    = sec_d;

endmodule
`default_nettype wire

// File: rtl/sync_transmitter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sync_transmitter: broadcasts the seconds count as a UART frame  1.0|
// +-------------------------------------------------------------------+
module sync_transmitter
  import sync_pkg::*;
#(
  parameter int SEC_DIV = DEF_SEC_DIV,
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  wire logic          clk_10M,
  input  wire logic          rst,
  sync_transmitter_if.slave  bus
);

  localparam int         BW        = $clog2(BIT_DIV);
  localparam logic [2:0] LAST_DATA = 3'(FRAME_BITS - 3);

  state_e        state_q;
  logic [BW-1:0] bcnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          pend_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          ovr_q;

  logic          sec_tick;
  logic [7:0]    sec_next;
  logic          trig;
  logic          bit_end;

  sync_time_base #(
    .SEC_DIV (SEC_DIV)
  ) u_time_base (
    .clk_10M       (clk_10M),
    .rst           (rst),
    .time_load_i   (bus.time_load),
    .time_in_i     (bus.time_in),
    .time_second_o (bus.time_second),
    .sec_tick_o    (sec_tick),
    .sec_next_o    (sec_next)
  );

  assign trig    = sec_tick | bus.sync_req;
  assign bit_end = (bcnt_q == BW'(BIT_DIV - 1));

  always_ff @(posedge clk_10M) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bcnt_q <= bit_end ? '0 : bcnt_q + BW'(1);
      case (state_q)
        ST_IDLE: begin
          bcnt_q <= '0;
          if (trig || pend_q) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            shift_q <= sec_next;
            // A launch from pend alongside a fresh trigger keeps one queued.
            pend_q  <= pend_q & trig;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_DATA) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (bcnt_q == BW'(BIT_DIV - 2)) done_q <= 1'b1;
          if (bit_end) begin
            if (pend_q) begin
              state_q <= ST_START;
              tx_q    <= 1'b0;
              shift_q <= sec_next;
              pend_q  <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Requests arriving mid-frame queue once; a second one is lost.
      if (trig && (state_q != ST_IDLE)) begin
        if (pend_q) ovr_q  <= 1'b1;
        else        pend_q <= 1'b1;
      end
    end
  end

  assign bus.tx_line  = tx_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.sec_tick = sec_tick;
  assign bus.overrun  = ovr_q;

endmodule
`default_nettype wire
